// File: rtl/dcache_meta_array.sv
// dcache_meta_array: per-set/way tag and coherence metadata with post-reset invalidation sweep
module dcache_meta_array #(
  parameter int N_SETS = 128,
  parameter int IDX_W  = 7,
  parameter int N_WAYS = 1,
  parameter int TAG_W  = 19,
  parameter int COH_W  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      io_write_ready,
  input  logic                      io_write_valid,
  input  logic [IDX_W-1:0]          io_write_bits_idx,
  input  logic [N_WAYS-1:0]         io_write_bits_way_en,
  input  logic [TAG_W-1:0]          io_write_bits_data_tag,
  input  logic [COH_W-1:0]          io_write_bits_data_coh_state,
  output logic                      io_read_ready,
  input  logic                      io_read_valid,
  input  logic [IDX_W-1:0]          io_read_bits_idx,
  output logic                      io_resp_valid,
  output logic [N_WAYS*TAG_W-1:0]   io_resp_tag,
  output logic [N_WAYS*COH_W-1:0]   io_resp_coh_state,
  output logic                      io_init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t                    state_q, state_d;
  logic [IDX_W:0]            rst_cnt_q, rst_cnt_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [N_WAYS*TAG_W-1:0]   resp_tag_q, resp_tag_d, rd_tag;
  logic [N_WAYS*COH_W-1:0]   resp_coh_q, resp_coh_d, rd_coh;
  logic [TAG_W-1:0]          tag_mem [N_SETS][N_WAYS];
  logic [COH_W-1:0]          coh_mem [N_SETS][N_WAYS];
  logic                      wr_en, rd_fire;
  logic [IDX_W-1:0]          wr_idx;
  logic [N_WAYS-1:0]         wr_mask;
  logic [TAG_W-1:0]          wr_tag;
  logic [COH_W-1:0]          wr_coh;

  assign io_init_done      = state_q == RUN;
  assign io_write_ready    = state_q == RUN;
  assign io_read_ready     = (state_q == RUN) && !io_write_valid;
  assign io_resp_valid     = resp_valid_q;
  assign io_resp_tag       = resp_tag_q;
  assign io_resp_coh_state = resp_coh_q;

  // sweep counter advances every INIT cycle; its carry into the top bit marks the last set
  always_comb begin
    rst_cnt_d = state_q == INIT ? rst_cnt_q + 1'b1 : rst_cnt_q;
    state_d   = (state_q == INIT && rst_cnt_d[IDX_W]) ? RUN : state_q;
  end

  // single storage write port shared by the sweep and the arbiter's write
  always_comb begin
    wr_en   = (state_q == INIT) || (io_write_valid && io_write_ready);
    wr_idx  = state_q == INIT ? rst_cnt_q[IDX_W-1:0] : io_write_bits_idx;
    wr_mask = state_q == INIT ? '1 : io_write_bits_way_en;
    wr_tag  = state_q == INIT ? '0 : io_write_bits_data_tag;
    wr_coh  = state_q == INIT ? '0 : io_write_bits_data_coh_state;
  end

  // gather all ways of the requested set and hold the response when no read fires
  always_comb begin
    rd_fire = io_read_valid && io_read_ready;
    rd_tag  = '0;
    rd_coh  = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      rd_tag[w*TAG_W +: TAG_W] = tag_mem[io_read_bits_idx][w];
      rd_coh[w*COH_W +: COH_W] = coh_mem[io_read_bits_idx][w];
    end
    resp_valid_d = rd_fire;
    resp_tag_d   = rd_fire ? rd_tag : resp_tag_q;
    resp_coh_d   = rd_fire ? rd_coh : resp_coh_q;
  end

  // control and response registers; reset drops any in-flight response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      rst_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_coh_q   <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_coh_q   <= resp_coh_d;
    end
  end

  // storage cells carry no reset; the sweep clears them
  always_ff @(posedge clk) begin
    for (int w = 0; w < N_WAYS; w++) begin
      if (wr_en && wr_mask[w]) begin
        tag_mem[wr_idx][w] <= wr_tag;
        coh_mem[wr_idx][w] <= wr_coh;
      end
    end
  end
endmodule

// File: tb/tb_dcache_meta_array.sv
// tb_dcache_meta_array: scoreboard bench with a behavioural metadata model
module tb_dcache_meta_array;
  localparam int N_SETS = 128;
  localparam int IDX_W  = 7;
  localparam int N_WAYS = 1;
  localparam int TAG_W  = 19;
  localparam int COH_W  = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    io_write_ready;
  logic                    io_write_valid = 1'b0;
  logic [IDX_W-1:0]        io_write_bits_idx = '0;
  logic [N_WAYS-1:0]       io_write_bits_way_en = '0;
  logic [TAG_W-1:0]        io_write_bits_data_tag = '0;
  logic [COH_W-1:0]        io_write_bits_data_coh_state = '0;
  logic                    io_read_ready;
  logic                    io_read_valid = 1'b0;
  logic [IDX_W-1:0]        io_read_bits_idx = '0;
  logic                    io_resp_valid;
  logic [N_WAYS*TAG_W-1:0] io_resp_tag;
  logic [N_WAYS*COH_W-1:0] io_resp_coh_state;
  logic                    io_init_done;

  dcache_meta_array #(.N_SETS(N_SETS), .IDX_W(IDX_W), .N_WAYS(N_WAYS), .TAG_W(TAG_W), .COH_W(COH_W)) dut (
    .clk(clk), .reset(reset),
    .io_write_ready(io_write_ready), .io_write_valid(io_write_valid),
    .io_write_bits_idx(io_write_bits_idx), .io_write_bits_way_en(io_write_bits_way_en),
    .io_write_bits_data_tag(io_write_bits_data_tag), .io_write_bits_data_coh_state(io_write_bits_data_coh_state),
    .io_read_ready(io_read_ready), .io_read_valid(io_read_valid), .io_read_bits_idx(io_read_bits_idx),
    .io_resp_valid(io_resp_valid), .io_resp_tag(io_resp_tag), .io_resp_coh_state(io_resp_coh_state),
    .io_init_done(io_init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_WAYS*TAG_W-1:0] tag;
    logic [N_WAYS*COH_W-1:0] coh;
  } resp_t;

  int total = 0;
  int bad = 0;
  int since = 0;
  resp_t exp_q[$];
  logic [TAG_W-1:0] m_tag [N_SETS][N_WAYS];
  logic [COH_W-1:0] m_coh [N_SETS][N_WAYS];

  always @(posedge clk or posedge reset) since <= reset ? 0 : since + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < N_SETS; s++)
      for (int w = 0; w < N_WAYS; w++) begin
        m_tag[s][w] = '0;
        m_coh[s][w] = '0;
      end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    io_write_valid = 1'b0;
    io_read_valid  = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    model_clear();
    #1;
    check("rst_resp_valid", io_resp_valid, 0);
    check("rst_resp_tag", io_resp_tag, 0);
    check("rst_resp_coh", io_resp_coh_state, 0);
    check("rst_write_ready", io_write_ready, 0);
    check("rst_read_ready", io_read_ready, 0);
    check("rst_init_done", io_init_done, 0);
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic wv, input logic [IDX_W-1:0] widx, input logic [N_WAYS-1:0] wway,
                      input logic [TAG_W-1:0] wtag, input logic [COH_W-1:0] wcoh,
                      input logic rv, input logic [IDX_W-1:0] ridx);
    logic run;
    resp_t e;
    @(negedge clk);
    io_write_valid = wv;
    io_write_bits_idx = widx;
    io_write_bits_way_en = wway;
    io_write_bits_data_tag = wtag;
    io_write_bits_data_coh_state = wcoh;
    io_read_valid = rv;
    io_read_bits_idx = ridx;
    #1;
    run = since >= N_SETS;
    check("write_ready", io_write_ready, run);
    check("read_ready", io_read_ready, run && !wv);
    check("init_done", io_init_done, run);
    if (rv && run && !wv) begin
      e = '0;
      for (int w = 0; w < N_WAYS; w++) begin
        e.tag[w*TAG_W +: TAG_W] = m_tag[ridx][w];
        e.coh[w*COH_W +: COH_W] = m_coh[ridx][w];
      end
      exp_q.push_back(e);
    end
    if (wv && run)
      for (int w = 0; w < N_WAYS; w++)
        if (wway[w]) begin
          m_tag[widx][w] = wtag;
          m_coh[widx][w] = wcoh;
        end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [IDX_W-1:0] idx, input logic [N_WAYS-1:0] way, input logic [TAG_W-1:0] tag, input logic [COH_W-1:0] coh);
    step(1'b1, idx, way, tag, coh, 1'b0, '0);
  endtask

  task automatic rd(input logic [IDX_W-1:0] idx);
    step(1'b0, '0, '0, '0, '0, 1'b1, idx);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && since < N_SETS; i++) idle();
    check("sweep_timeout", since >= N_SETS, 1);
  endtask

  initial begin : mon
    resp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (io_resp_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp actual=1 required=0 t=%0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("resp_tag", io_resp_tag, e.tag);
            check("resp_coh", io_resp_coh_state, e.coh);
          end
        end else if (exp_q.size() != 0) begin
          total++;
          bad++;
          $display("FAIL missing_resp actual=0 required=1 t=%0t", $time);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    do_reset(2);
    for (int i = 0; i < 130; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 7'h55);
    idle();
    wr(7'h12, 1'b1, 19'h4ABCD, 2'd2);
    rd(7'h12);
    idle();
    step(1'b1, 7'h20, 1'b1, 19'h00111, 2'd1, 1'b1, 7'h20);
    rd(7'h20);
    idle();
    wr(7'h12, 1'b0, 19'h00001, 2'd1);
    rd(7'h12);
    idle();
    rd(7'h12);
    do_reset(2);
    for (int i = 0; i < 60; i++) idle();
    do_reset(2);
    wait_run();
    rd(7'h12);
    rd(7'h20);
    idle();
    wr(7'h7F, 1'b1, 19'h7FFFF, 2'd3);
    wr(7'h00, 1'b1, 19'h00AAA, 2'd1);
    rd(7'h7F);
    rd(7'h00);
    rd(7'h7F);
    idle();
    for (int i = 0; i < 800; i++) begin
      logic [IDX_W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? IDX_W'($urandom) : IDX_W'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? IDX_W'($urandom) : IDX_W'($urandom_range(0, 7));
      step($urandom_range(0, 2) == 0, a, N_WAYS'($urandom), TAG_W'($urandom), COH_W'($urandom),
           $urandom_range(0, 1) == 1, b);
    end
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
